// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
// Optional address range check enabled by defining SRAM_ADDR_CHECK_EN.
package mem_sram_ctrl_pkg;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam int SRAM_AW = 17;
   localparam int SRAM_DW = 32;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

endpackage

// File: rtl/mem_sram_ctrl_wait.sv
// Access-length counter: cleared on entry, terminal count on the last
// ACCESS cycle.
module sram_wait_counter
   import mem_sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 5
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !tc_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Multi-cycle SRAM controller that freezes the pipeline via ready.
// Define SRAM_ADDR_CHECK_EN to reject out-of-range addresses.
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 5,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_we_n,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               addr_err
);

   state_t             state_q, state_d;
   logic               wr_q, wr_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [SRAM_DW-1:0] wdata_q, wdata_d;
   logic [SRAM_DW-1:0] rdata_q, rdata_d;
   logic [31:0]        offset;
   logic               req, bad, tc, cnt_clr, cnt_en;
   logic               unused_ok;

   assign offset    = address - BASE_ADDR;
   assign req       = wr_en | rd_en;
   assign unused_ok = ^{offset[1:0], offset[31:SRAM_AW+2]};

`ifdef SRAM_ADDR_CHECK_EN
   logic err_q, err_d;

   assign bad   = (address < BASE_ADDR) || (offset[31:19] != '0);
   assign err_d = (state_q == IDLE) && req && bad;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign addr_err = err_q;
`else
   assign bad      = 1'b0;
   assign addr_err = 1'b0;
`endif

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk_i (clk),
      .rst_ni(rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (tc)
   );

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      ready       = 1'b0;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = '0;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            ready   = !req;
            if (req) begin
               wr_d    = wr_en;
               addr_d  = offset[SRAM_AW+1:2];
               wdata_d = write_data;
               state_d = bad ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            cnt_en = 1'b1;
            if (wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q;
               // strobe rises one cycle early so data holds past WE#
               sram_we_n   = tc && (WAIT_CYCLES != 1);
            end
            if (tc) begin
               state_d = DONE;
               if (!wr_q)
                  rdata_d = sram_dq_in;
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign read_data = rdata_q;
   assign sram_addr = addr_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a small behavioural SRAM.
// Range-check steps compile only with SRAM_ADDR_CHECK_EN.
module tb_mem_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [16:0] sram_addr;
   logic        sram_we_n;
   logic [31:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [31:0] sram_dq_in;
   logic        addr_err;

   logic [31:0] mem [0:15];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;

   int total = 0;
   int bad = 0;
   int span;

   always #5 clk = ~clk;

   mem_sram_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_we_n  (sram_we_n),
      .sram_dq_out(sram_dq_out),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_in (sram_dq_in),
      .addr_err   (addr_err)
   );

   assign sram_dq_in = mem[sram_addr[3:0]];

   always @(posedge clk) begin
      if (pre_en)
         mem[pre_idx] <= pre_val;
      else if (!sram_we_n && sram_dq_oe)
         mem[sram_addr[3:0]] <= sram_dq_out;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [3:0] idx, input logic [31:0] val);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      tick();
      pre_en  = 1'b0;
   endtask

   // count ready-low cycles from the current one; ends in the DONE cycle
   task automatic run_span(input bit drop, output int n);
      n = 0;
      while (ready === 1'b0 && n < 20) begin
         n++;
         tick();
         if (drop) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
         end
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #12;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_dq_out", sram_dq_out, 32'd0);
      check("rst_rdata", read_data, 32'd0);
      check("rst_err", 32'(addr_err), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // write DEADBEEF to word 1
      wr_en = 1'b1;
      address = 32'd1028;
      write_data = 32'hDEADBEEF;
      #1;
      check("w_c0_ready", 32'(ready), 32'd0);
      tick();
      wr_en = 1'b0;
      address = 32'hFFFF_FFF0;
      write_data = '0;
      #1;
      for (int c = 1; c <= 5; c++) begin
         check("w_addr", 32'(sram_addr), 32'd1);
         check("w_we_n", 32'(sram_we_n), 32'(c == 5));
         check("w_oe", 32'(sram_dq_oe), 32'd1);
         check("w_dq_out", sram_dq_out, 32'hDEADBEEF);
         check("w_ready", 32'(ready), 32'd0);
         tick();
         #1;
      end
      check("w_c6_ready", 32'(ready), 32'd1);
      check("w_c6_we_n", 32'(sram_we_n), 32'd1);
      check("w_c6_oe", 32'(sram_dq_oe), 32'd0);
      tick();
      #1;
      check("w_idle_ready", 32'(ready), 32'd1);
      check("w_mem1", mem[1], 32'hDEADBEEF);
      check("w_rdata_keep", read_data, 32'd0);

      // read word 1
      poke(4'd1, 32'h12345678);
      rd_en = 1'b1;
      address = 32'd1028;
      #1;
      check("r_c0_ready", 32'(ready), 32'd0);
      tick();
      rd_en = 1'b0;
      address = '0;
      #1;
      for (int c = 1; c <= 5; c++) begin
         check("r_we_n", 32'(sram_we_n), 32'd1);
         check("r_oe", 32'(sram_dq_oe), 32'd0);
         check("r_ready", 32'(ready), 32'd0);
         tick();
         #1;
      end
      check("r_c6_ready", 32'(ready), 32'd1);
      check("r_c6_rdata", read_data, 32'h12345678);
      tick();
      #1;
      check("r_hold_rdata", read_data, 32'h12345678);

      // both enables -> write to word 2
      poke(4'd2, 32'd0);
      wr_en = 1'b1;
      rd_en = 1'b1;
      address = 32'd1032;
      write_data = 32'hA5A50F0F;
      #1;
      run_span(1'b1, span);
      check("both_span", 32'(span), 32'd6);
      check("both_mem2", mem[2], 32'hA5A50F0F);
      check("both_rdata", read_data, 32'h12345678);
      tick();
      #1;

      // reset during cycle 3 of a write
      wr_en = 1'b1;
      address = 32'd1036;
      write_data = 32'h11111111;
      #1;
      tick();
      wr_en = 1'b0;
      tick();
      tick();
      #1;
      check("rm_we_active", 32'(sram_we_n), 32'd0);
      rst = 1'b0;
      #1;
      check("rm_we_n", 32'(sram_we_n), 32'd1);
      check("rm_oe", 32'(sram_dq_oe), 32'd0);
      check("rm_ready", 32'(ready), 32'd1);
      check("rm_addr", 32'(sram_addr), 32'd0);
      check("rm_dq_out", sram_dq_out, 32'd0);
      check("rm_rdata", read_data, 32'd0);
      tick();
      rst = 1'b1;
      #1;
      rd_en = 1'b1;
      address = 32'd1028;
      #1;
      run_span(1'b1, span);
      check("rm_next_span", 32'(span), 32'd6);
      check("rm_next_rdata", read_data, 32'h12345678);
      tick();
      #1;

      // back-to-back read then write with enables held
      poke(4'd4, 32'hCAFEF00D);
      rd_en = 1'b1;
      address = 32'd1040;
      #1;
      run_span(1'b0, span);
      check("b2b_rd_span", 32'(span), 32'd6);
      check("b2b_rd_data", read_data, 32'hCAFEF00D);
      rd_en = 1'b0;
      wr_en = 1'b1;
      address = 32'd1044;
      write_data = 32'h0BADC0DE;
      #1;
      check("b2b_done_ready", 32'(ready), 32'd1);
      tick();
      #1;
      check("b2b_wr_start", 32'(ready), 32'd0);
      run_span(1'b1, span);
      check("b2b_wr_span", 32'(span), 32'd6);
      check("b2b_mem5", mem[5], 32'h0BADC0DE);
      check("b2b_rdata", read_data, 32'hCAFEF00D);
      tick();
      #1;

`ifdef SRAM_ADDR_CHECK_EN
      rd_en = 1'b1;
      address = 32'd512;
      #1;
      check("err_c0_ready", 32'(ready), 32'd0);
      tick();
      rd_en = 1'b0;
      #1;
      check("err_done_ready", 32'(ready), 32'd1);
      check("err_flag", 32'(addr_err), 32'd1);
      check("err_we_n", 32'(sram_we_n), 32'd1);
      check("err_rdata", read_data, 32'hCAFEF00D);
      tick();
      #1;
      check("err_clear", 32'(addr_err), 32'd0);
`else
      check("noerr_flag", 32'(addr_err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
